// File: rtl/oven_display_scan_if.sv
// Display-side bundle: BCD pair and display controls in, multiplexed segment/anode pins out.
interface oven_display_scan_if;
  logic [7:0] digit_time;
  logic       blank_lz;
  logic       blink_en;
  logic [6:0] seg;
  logic [1:0] an;

  modport master (output digit_time, blank_lz, blink_en, input seg, an);
  modport slave  (input digit_time, blank_lz, blink_en, output seg, an);
endinterface

// File: rtl/oven_display_scan.sv
// Two-digit multiplexed 7-segment scanner: per-frame input latch, BCD decode,
// optional leading-zero blanking and whole-display blink.
module oven_display_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 125,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                clk,
  input  logic                rst,
  oven_display_scan_if.slave  bus
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic          POL        = (ACTIVE_LOW != 0);

  logic [SW-1:0] r_scan_cnt;
  logic          r_sel;
  logic [FW-1:0] r_frame_cnt;
  logic          r_phase;
  logic [3:0]    r_tens;
  logic [3:0]    r_units;
  logic [6:0]    r_seg;
  logic [1:0]    r_an;

  logic          w_scan_wrap;
  logic          w_frame_end;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg_on;
  logic [1:0]    w_an_on;
  logic          w_blank;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    case (d)
      4'd0:    f_decode = 7'h3F;
      4'd1:    f_decode = 7'h06;
      4'd2:    f_decode = 7'h5B;
      4'd3:    f_decode = 7'h4F;
      4'd4:    f_decode = 7'h66;
      4'd5:    f_decode = 7'h6D;
      4'd6:    f_decode = 7'h7D;
      4'd7:    f_decode = 7'h07;
      4'd8:    f_decode = 7'h7F;
      4'd9:    f_decode = 7'h6F;
      default: f_decode = 7'h40;
    endcase
  endfunction

  always_comb begin
    w_scan_wrap = (r_scan_cnt == SCAN_LAST);
    w_frame_end = w_scan_wrap && r_sel;
    w_digit     = r_sel ? r_tens : r_units;
    w_seg_on    = f_decode(w_digit);
    w_an_on     = r_sel ? 2'b10 : 2'b01;
    // Blink off-phase wins; leading-zero blanking only ever hits the tens slot.
    w_blank     = (bus.blink_en && r_phase) ||
                  (r_sel && bus.blank_lz && (r_tens == 4'd0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt  <= '0;
      r_sel       <= 1'b0;
      r_frame_cnt <= '0;
      r_phase     <= 1'b0;
      r_tens      <= 4'd0;
      r_units     <= 4'd0;
      r_seg       <= {7{POL}};
      r_an        <= {2{POL}};
    end else begin
      if (w_scan_wrap) begin
        r_scan_cnt <= '0;
        r_sel      <= ~r_sel;
      end else begin
        r_scan_cnt <= r_scan_cnt + SW'(1);
      end

      // Capture only at frame end so both digits of a frame come from one sample.
      if (w_frame_end) begin
        r_tens  <= bus.digit_time[7:4];
        r_units <= bus.digit_time[3:0];
        if (r_frame_cnt == FRAME_LAST) begin
          r_frame_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + FW'(1);
        end
      end

      r_seg <= (w_blank ? 7'h00 : w_seg_on) ^ {7{POL}};
      r_an  <= (w_blank ? 2'b00 : w_an_on)  ^ {2{POL}};
    end
  end

  assign bus.seg = r_seg;
  assign bus.an  = r_an;
endmodule

// File: tb/tb_oven_display_scan.sv
// Bench for oven_display_scan: arithmetic reference model checked every cycle on
// an active-high and an active-low instance, plus hand-computed pin values.
module tb_oven_display_scan;
  localparam int SD = 4;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] digit_time = 8'h42;
  logic       blank_lz = 1'b0;
  logic       blink_en = 1'b0;

  int npass = 0;
  int ntot  = 0;
  int ecnt  = 0;
  logic chk_on = 1'b0;
  logic [7:0] m_lat = 8'h00;
  logic [6:0] exp_seg = 7'h00;
  logic [1:0] exp_an  = 2'b00;

  oven_display_scan_if if0 ();
  oven_display_scan_if if1 ();

  assign if0.digit_time = digit_time;
  assign if0.blank_lz   = blank_lz;
  assign if0.blink_en   = blink_en;
  assign if1.digit_time = digit_time;
  assign if1.blank_lz   = blank_lz;
  assign if1.blink_en   = blink_en;

  oven_display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF), .ACTIVE_LOW(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0));
  oven_display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF), .ACTIVE_LOW(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  logic [6:0] segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  // Logical {an,seg} produced at the edge that follows n un-reset edges.
  function automatic logic [8:0] model_out(int n, logic [7:0] lat, logic blz, logic ben);
    int sel, phase;
    logic [3:0] d;
    sel   = (n / SD) % 2;
    phase = (n / (2 * SD * BF)) % 2;
    if (ben && phase == 1) return 9'h000;
    if (sel == 1) begin
      d = lat[7:4];
      if (blz && d == 4'd0) return 9'h000;
      return {2'b10, segtab[d]};
    end
    d = lat[3:0];
    return {2'b01, segtab[d]};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ecnt    <= 0;
      m_lat   <= 8'h00;
      exp_an  <= 2'b00;
      exp_seg <= 7'h00;
    end else begin
      {exp_an, exp_seg} <= model_out(ecnt, m_lat, blank_lz, blink_en);
      if ((ecnt + 1) % (2 * SD) == 0) m_lat <= digit_time;
      ecnt <= ecnt + 1;
    end
  end

  task automatic chk(string name, logic [8:0] act, logic [8:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s at t=%0t k=%0d: got %h want %h", name, $time, ecnt, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_hi", {if0.an, if0.seg}, {exp_an, exp_seg});
      chk("model_lo", {if1.an, if1.seg}, ~{exp_an, exp_seg});
      chk("onehot",   {8'h00, ($countones(if0.an) <= 1)}, 9'h001);
    end
  end

  task automatic lit(string name, logic [1:0] an, logic [6:0] seg);
    chk(name, {if0.an, if0.seg}, {an, seg});
  endtask

  task automatic lit_lo(string name, logic [1:0] an, logic [6:0] seg);
    chk(name, {if1.an, if1.seg}, {an, seg});
  endtask

  task automatic goto(int k);
    int g = 0;
    while (ecnt < k && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (ecnt != k) begin
      ntot++;
      $display("FAIL goto: reached k=%0d want %0d", ecnt, k);
    end
  endtask

  initial begin
    // Reset held three edges with 42 on the input.
    repeat (3) begin
      @(negedge clk);
      chk_on = 1'b1;
      lit("rst_hi", 2'b00, 7'h00);
      lit_lo("rst_lo", 2'b11, 7'h7F);
    end
    rst = 1'b0;

    goto(1);  lit("pre_u1", 2'b01, 7'h3F);
    goto(4);  lit("pre_u4", 2'b01, 7'h3F);
    goto(5);  lit("pre_t5", 2'b10, 7'h3F);
    goto(9);  lit("first_units", 2'b01, 7'h5B);
    goto(13); lit("first_tens", 2'b10, 7'h66);

    // Frame latch: 12 captured at edge 16, 37 changed mid-frame and shown from 25.
    digit_time = 8'h12;
    goto(21); lit("latch_12_t", 2'b10, 7'h06);
    digit_time = 8'h37;
    goto(23); lit("latch_hold", 2'b10, 7'h06);
    goto(25); lit("latch_37_u", 2'b01, 7'h07);
    goto(29); lit("latch_37_t", 2'b10, 7'h4F);

    // Leading-zero blanking.
    digit_time = 8'h05; blank_lz = 1'b1;
    goto(33); lit("lz_units", 2'b01, 7'h6D);
    goto(37); lit("lz_tens_blank", 2'b00, 7'h00);
    blank_lz = 1'b0;
    goto(38); lit("lz_tens_zero", 2'b10, 7'h3F);

    // Non-BCD tens shows a dash, even with blanking requested.
    digit_time = 8'hA9;
    goto(41); lit("bad_units", 2'b01, 7'h6F);
    goto(45); lit("bad_tens", 2'b10, 7'h40);
    blank_lz = 1'b1;
    goto(46); lit("bad_tens_lz", 2'b10, 7'h40);

    // Blink: off for edges 49..64, on 65..80, off from 81.
    digit_time = 8'h99; blank_lz = 1'b0; blink_en = 1'b1;
    goto(49); lit("blink_off_a", 2'b00, 7'h00);
    goto(64); lit("blink_off_b", 2'b00, 7'h00);
    goto(65); lit("blink_on_a", 2'b01, 7'h6F);
    goto(80); lit("blink_on_b", 2'b10, 7'h6F);
    goto(81); lit("blink_off_c", 2'b00, 7'h00);
    goto(85); lit("blink_off_d", 2'b00, 7'h00);
    blink_en = 1'b0;
    goto(86); lit("blink_drop", 2'b10, 7'h6F);
    blink_en = 1'b1;
    goto(87); lit("blink_reoff", 2'b00, 7'h00);

    // Reset during blink-off phase.
    rst = 1'b1;
    @(negedge clk);
    lit("mid_rst_hi", 2'b00, 7'h00);
    lit_lo("mid_rst_lo", 2'b11, 7'h7F);
    @(negedge clk);
    rst = 1'b0;
    goto(1);
    lit("post_rst_hi", 2'b01, 7'h3F);
    lit_lo("post_rst_lo", 2'b10, 7'h40);
    goto(9);  lit("post_rst_99", 2'b01, 7'h6F);
    goto(17); lit("post_rst_blink", 2'b00, 7'h00);
    goto(24);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
